// File: rtl/regfile_tagged.sv
// Architectural register file with per-register rename tracking.
// Each register holds a committed value, a busy bit and the ROB tag of the
// youngest in-flight writer. Reads are registered and see the post-commit,
// pre-issue view of the current cycle. Register 0 is hard-wired to zero.
module regfile_tagged #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int ROB_W  = 4,
   parameter int NUM_RD = 2
) (
   input  logic                              clk_in,
   input  logic                              rst_in,
   input  logic                              rdy_in,
   input  logic                              rd_valid_in,
   input  logic [NUM_RD*$clog2(NREG)-1:0]    rd_addr_in,
   output logic [NUM_RD*XLEN-1:0]            rd_data_out,
   output logic [NUM_RD-1:0]                 rd_busy_out,
   output logic [NUM_RD*ROB_W-1:0]           rd_tag_out,
   input  logic                              iss_valid_in,
   input  logic [$clog2(NREG)-1:0]           iss_rd_in,
   input  logic [ROB_W-1:0]                  iss_tag_in,
   input  logic                              cmt_valid_in,
   input  logic [$clog2(NREG)-1:0]           cmt_rd_in,
   input  logic [ROB_W-1:0]                  cmt_tag_in,
   input  logic [XLEN-1:0]                   cmt_data_in,
   input  logic                              flush_in
);

   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0]  data_q [NREG];
   logic [XLEN-1:0]  data_d [NREG];
   logic [ROB_W-1:0] tag_q  [NREG];
   logic [ROB_W-1:0] tag_d  [NREG];
   logic [NREG-1:0]  busy_q, busy_d;

   logic [NUM_RD*XLEN-1:0]  rd_data_q, rd_data_d;
   logic [NUM_RD-1:0]       rd_busy_q, rd_busy_d;
   logic [NUM_RD*ROB_W-1:0] rd_tag_q, rd_tag_d;

   logic cmt_hit;
   logic cmt_clr;
   logic iss_hit;

   // A commit always writes data; it only retires the rename if it is still
   // the youngest producer, otherwise a later writer keeps the register busy.
   assign cmt_hit = cmt_valid_in && (cmt_rd_in != '0);
   assign cmt_clr = cmt_hit && busy_q[cmt_rd_in] && (tag_q[cmt_rd_in] == cmt_tag_in);
   assign iss_hit = iss_valid_in && (iss_rd_in != '0) && !flush_in;

   // Next architectural/rename state: commit first, then flush or issue on top.
   always_comb begin
      data_d = data_q;
      tag_d  = tag_q;
      busy_d = busy_q;
      if (cmt_hit) data_d[cmt_rd_in] = cmt_data_in;
      if (cmt_clr) busy_d[cmt_rd_in] = 1'b0;
      if (flush_in) begin
         busy_d = '0;
      end else if (iss_hit) begin
         busy_d[iss_rd_in] = 1'b1;
         tag_d[iss_rd_in]  = iss_tag_in;
      end
   end

   // Per-port read with commit bypass; same-cycle issue is deliberately hidden
   // so a source equal to the dispatching destination sees the old producer.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] addr;
      logic          hit;
      assign addr = rd_addr_in[k*AW +: AW];
      assign hit  = cmt_hit && (cmt_rd_in == addr);
      assign rd_data_d[k*XLEN +: XLEN]   = hit ? cmt_data_in : data_q[addr];
      assign rd_busy_d[k]                = busy_q[addr] && !(hit && cmt_clr) && !flush_in;
      assign rd_tag_d[k*ROB_W +: ROB_W]  = tag_q[addr];
   end

   // Register state update; register 0 is never written so it stays zero.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < NREG; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
         busy_q <= '0;
      end else if (rdy_in) begin
         for (int i = 0; i < NREG; i++) begin
            data_q[i] <= data_d[i];
            tag_q[i]  <= tag_d[i];
         end
         busy_q <= busy_d;
      end
   end

   // Registered read results, held until the next accepted request.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rd_data_q <= '0;
         rd_busy_q <= '0;
         rd_tag_q  <= '0;
      end else if (rdy_in && rd_valid_in) begin
         rd_data_q <= rd_data_d;
         rd_busy_q <= rd_busy_d;
         rd_tag_q  <= rd_tag_d;
      end
   end

   assign rd_data_out = rd_data_q;
   assign rd_busy_out = rd_busy_q;
   assign rd_tag_out  = rd_tag_q;

endmodule

// File: tb/tb_regfile_tagged.sv
// Directed, table-driven bench for regfile_tagged.
module tb_regfile_tagged;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int ROB_W = 4;
   localparam int NUM_RD = 2;
   localparam int AW = 5;

   logic                     clk_in = 1'b0;
   logic                     rst_in;
   logic                     rdy_in;
   logic                     rd_valid_in;
   logic [NUM_RD*AW-1:0]     rd_addr_in;
   logic [NUM_RD*XLEN-1:0]   rd_data_out;
   logic [NUM_RD-1:0]        rd_busy_out;
   logic [NUM_RD*ROB_W-1:0]  rd_tag_out;
   logic                     iss_valid_in;
   logic [AW-1:0]            iss_rd_in;
   logic [ROB_W-1:0]         iss_tag_in;
   logic                     cmt_valid_in;
   logic [AW-1:0]            cmt_rd_in;
   logic [ROB_W-1:0]         cmt_tag_in;
   logic [XLEN-1:0]          cmt_data_in;
   logic                     flush_in;

   regfile_tagged #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NUM_RD(NUM_RD)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rd_valid_in(rd_valid_in),
      .rd_addr_in(rd_addr_in), .rd_data_out(rd_data_out), .rd_busy_out(rd_busy_out),
      .rd_tag_out(rd_tag_out), .iss_valid_in(iss_valid_in), .iss_rd_in(iss_rd_in),
      .iss_tag_in(iss_tag_in), .cmt_valid_in(cmt_valid_in), .cmt_rd_in(cmt_rd_in),
      .cmt_tag_in(cmt_tag_in), .cmt_data_in(cmt_data_in), .flush_in(flush_in)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic        rdy, rv;
      logic [4:0]  a0, a1;
      logic        iv;
      logic [4:0]  ird;
      logic [3:0]  itag;
      logic        cv;
      logic [4:0]  crd;
      logic [3:0]  ctag;
      logic [31:0] cdata;
      logic        fl;
      logic [31:0] d0; logic b0; logic [3:0] t0;
      logic [31:0] d1; logic b1; logic [3:0] t1;
   } vec_t;

   vec_t vt [$];
   int errors = 0;
   int checks = 0;

   function automatic vec_t mk(input logic rdy, rv, input logic [4:0] a0, a1,
                               input logic iv, input logic [4:0] ird, input logic [3:0] itag,
                               input logic cv, input logic [4:0] crd, input logic [3:0] ctag,
                               input logic [31:0] cdata, input logic fl,
                               input logic [31:0] d0, input logic b0, input logic [3:0] t0,
                               input logic [31:0] d1, input logic b1, input logic [3:0] t1);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.a0 = a0; v.a1 = a1;
      v.iv = iv; v.ird = ird; v.itag = itag;
      v.cv = cv; v.crd = crd; v.ctag = ctag; v.cdata = cdata; v.fl = fl;
      v.d0 = d0; v.b0 = b0; v.t0 = t0; v.d1 = d1; v.b1 = b1; v.t1 = t1;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
      end
   endtask

   task automatic chk_port(input int idx, input logic [31:0] d0, input logic b0, input logic [3:0] t0,
                           input logic [31:0] d1, input logic b1, input logic [3:0] t1);
      chk("data0", idx, rd_data_out[31:0], d0);
      chk("busy0", idx, {31'b0, rd_busy_out[0]}, {31'b0, b0});
      chk("tag0",  idx, {28'b0, rd_tag_out[3:0]}, {28'b0, t0});
      chk("data1", idx, rd_data_out[63:32], d1);
      chk("busy1", idx, {31'b0, rd_busy_out[1]}, {31'b0, b1});
      chk("tag1",  idx, {28'b0, rd_tag_out[7:4]}, {28'b0, t1});
   endtask

   task automatic idle();
      rdy_in = 1'b1; rd_valid_in = 1'b0; rd_addr_in = '0;
      iss_valid_in = 1'b0; iss_rd_in = '0; iss_tag_in = '0;
      cmt_valid_in = 1'b0; cmt_rd_in = '0; cmt_tag_in = '0; cmt_data_in = '0;
      flush_in = 1'b0;
   endtask

   initial begin
      //      rdy rv a0 a1  iv ird it  cv crd ct cdata         fl  d0 b0 t0 / d1 b1 t1
      vt.push_back(mk(1,1, 5, 0, 0,0,0, 0,0,0,32'h0,0,         32'h0,0,0, 32'h0,0,0));
      vt.push_back(mk(1,0, 0, 0, 1,3,7, 0,0,0,32'h0,0,         32'h0,0,0, 32'h0,0,0));
      vt.push_back(mk(1,1, 3, 3, 0,0,0, 0,0,0,32'h0,0,         32'h0,1,7, 32'h0,1,7));
      vt.push_back(mk(1,1, 3, 0, 0,0,0, 1,3,7,32'hDEADBEEF,0,  32'hDEADBEEF,0,7, 32'h0,0,0));
      vt.push_back(mk(1,1, 3, 3, 1,4,2, 0,0,0,32'h0,0,         32'hDEADBEEF,0,7, 32'hDEADBEEF,0,7));
      vt.push_back(mk(1,1, 4, 4, 1,4,9, 0,0,0,32'h0,0,         32'h0,1,2, 32'h0,1,2));
      vt.push_back(mk(1,1, 4, 3, 0,0,0, 1,4,2,32'h11,0,        32'h11,1,9, 32'hDEADBEEF,0,7));
      vt.push_back(mk(1,1, 4, 4, 0,0,0, 0,0,0,32'h0,0,         32'h11,1,9, 32'h11,1,9));
      vt.push_back(mk(1,0, 0, 0, 1,6,1, 0,0,0,32'h0,0,         32'h11,1,9, 32'h11,1,9));
      vt.push_back(mk(1,1, 6, 6, 1,6,5, 1,6,1,32'hA5A5,0,      32'hA5A5,0,1, 32'hA5A5,0,1));
      vt.push_back(mk(1,1, 6, 4, 0,0,0, 0,0,0,32'h0,0,         32'hA5A5,1,5, 32'h11,1,9));
      vt.push_back(mk(1,0, 0, 0, 1,1,3, 0,0,0,32'h0,0,         32'hA5A5,1,5, 32'h11,1,9));
      vt.push_back(mk(1,1, 1, 2, 1,2,4, 0,0,0,32'h0,0,         32'h0,1,3, 32'h0,0,0));
      vt.push_back(mk(1,1, 1, 2, 1,7,6, 0,0,0,32'h0,1,         32'h0,0,3, 32'h0,0,4));
      vt.push_back(mk(1,1, 7, 1, 0,0,0, 0,0,0,32'h0,0,         32'h0,0,0, 32'h0,0,3));
      vt.push_back(mk(1,1, 2, 6, 0,0,0, 0,0,0,32'h0,0,         32'h0,0,4, 32'hA5A5,0,5));
      vt.push_back(mk(1,1, 0, 0, 1,0,1, 1,0,0,32'h55,0,        32'h0,0,0, 32'h0,0,0));
      vt.push_back(mk(1,1, 0, 4, 0,0,0, 0,0,0,32'h0,0,         32'h0,0,0, 32'h11,0,9));
      vt.push_back(mk(0,1, 8, 8, 0,0,0, 1,8,0,32'h77,0,        32'h0,0,0, 32'h11,0,9));
      vt.push_back(mk(1,1, 8, 8, 0,0,0, 0,0,0,32'h0,0,         32'h0,0,0, 32'h0,0,0));
      vt.push_back(mk(0,0, 0, 0, 1,9,3, 0,0,0,32'h0,0,         32'h0,0,0, 32'h0,0,0));
      vt.push_back(mk(1,1, 9, 3, 0,0,0, 0,0,0,32'h0,0,         32'h0,0,0, 32'hDEADBEEF,0,7));
      vt.push_back(mk(1,1, 10,10,0,0,0, 1,10,0,32'hCAFE,1,     32'hCAFE,0,0, 32'hCAFE,0,0));
      vt.push_back(mk(1,1, 10,3, 0,0,0, 0,0,0,32'h0,0,         32'hCAFE,0,0, 32'hDEADBEEF,0,7));

      idle();
      rst_in = 1'b1;
      #12;
      chk_port(-1, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
      rst_in = 1'b0;
      @(posedge clk_in); #1;

      for (int i = 0; i < vt.size(); i++) begin
         rdy_in = vt[i].rdy; rd_valid_in = vt[i].rv;
         rd_addr_in = {vt[i].a1, vt[i].a0};
         iss_valid_in = vt[i].iv; iss_rd_in = vt[i].ird; iss_tag_in = vt[i].itag;
         cmt_valid_in = vt[i].cv; cmt_rd_in = vt[i].crd; cmt_tag_in = vt[i].ctag;
         cmt_data_in = vt[i].cdata; flush_in = vt[i].fl;
         @(posedge clk_in); #1;
         chk_port(i, vt[i].d0, vt[i].b0, vt[i].t0, vt[i].d1, vt[i].b1, vt[i].t1);
      end

      // Mid-run asynchronous reset: make x5 busy, read it, then pulse reset
      // between clock edges and expect outputs to clear without a clock.
      idle();
      iss_valid_in = 1'b1; iss_rd_in = 5'd5; iss_tag_in = 4'd2;
      @(posedge clk_in); #1;
      idle();
      rd_valid_in = 1'b1; rd_addr_in = {5'd3, 5'd5};
      @(posedge clk_in); #1;
      chk_port(100, 32'h0, 1'b1, 4'd2, 32'hDEADBEEF, 1'b0, 4'd7);
      idle();
      #2 rst_in = 1'b1;
      #1;
      chk_port(101, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
      #1 rst_in = 1'b0;
      @(posedge clk_in); #1;
      rd_valid_in = 1'b1; rd_addr_in = {5'd3, 5'd5};
      @(posedge clk_in); #1;
      chk_port(102, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
